// File: rtl/bht_update_queue.sv
// bht_update_queue: paces resolved conditional-branch outcomes into the BHT update port,
// one write per cycle, keeping same-entry writes SAME_ENTRY_GAP cycles apart.
//   clk_i, rst_ni (async, active-low)
//   flush_bp_i        drop every pending update and the history
//   debug_mode_i      hold issue, drop incoming branches
//   res_valid_i/res_ready_o, res_is_cbranch_i, res_pc_i, res_taken_i  resolved-branch input
//   bht_update_o      {valid, pc, taken}; valid only in the issuing cycle
//   pending_o         current queue occupancy

package config_pkg;
   typedef struct packed {
      int unsigned VLEN;
      bit          RVC;
   } cva6_cfg_t;
   localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, RVC: 1'b1};
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        taken;
   } bht_update_default_t;
endpackage

module bht_update_queue #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter type bht_update_t = config_pkg::bht_update_default_t,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned NR_ENTRIES = 1024,
   parameter int unsigned SAME_ENTRY_GAP = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_bp_i,
   input  logic                      debug_mode_i,
   input  logic                      res_valid_i,
   output logic                      res_ready_o,
   input  logic                      res_is_cbranch_i,
   input  logic [CVA6Cfg.VLEN-1:0]   res_pc_i,
   input  logic                      res_taken_i,
   output bht_update_t               bht_update_o,
   output logic [$clog2(DEPTH):0]    pending_o
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned IW = $clog2(NR_ENTRIES);
   localparam int unsigned OFS = CVA6Cfg.RVC ? 1 : 2;
   localparam int unsigned VLEN = CVA6Cfg.VLEN;
   logic [VLEN-1:0] pc_q [DEPTH];
   logic [DEPTH-1:0] taken_q;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PW:0] count_q;
   logic push, issue, hazard;
   logic [IW-1:0] head_idx;
   // ready looks only at the registered count, so a full queue refuses a push even while popping
   assign res_ready_o = count_q != (PW+1)'(DEPTH);
   assign pending_o = count_q;
   assign head_idx = pc_q[rd_ptr_q][IW+OFS-1:OFS];
   assign push = res_valid_i & res_ready_o & res_is_cbranch_i & ~debug_mode_i & ~flush_bp_i;
   assign issue = (count_q != '0) & ~debug_mode_i & ~flush_bp_i & ~hazard;
   always_comb begin
      bht_update_o = '0;
      if (issue) begin
         bht_update_o.valid = 1'b1;
         bht_update_o.pc    = pc_q[rd_ptr_q];
         bht_update_o.taken = taken_q[rd_ptr_q];
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_bp_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + (PW+1)'(push) - (PW+1)'(issue);
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_q[wr_ptr_q]    <= res_pc_i;
         taken_q[wr_ptr_q] <= res_taken_i;
      end
   end
   if (SAME_ENTRY_GAP == 0) begin : g_nohist
      assign hazard = 1'b0;
   end else begin : g_hist
      // slot 0 holds the previous cycle's issue, slot GAP-1 the oldest still guarded
      logic [SAME_ENTRY_GAP-1:0] hv_q;
      logic [IW-1:0] hidx_q [SAME_ENTRY_GAP];
      always_comb begin
         hazard = 1'b0;
         for (int i = 0; i < SAME_ENTRY_GAP; i++) hazard = hazard | (hv_q[i] & (hidx_q[i] == head_idx));
      end
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            hv_q <= '0;
            for (int i = 0; i < SAME_ENTRY_GAP; i++) hidx_q[i] <= '0;
         end else begin
            hv_q[0]   <= issue;
            hidx_q[0] <= head_idx;
            for (int i = 1; i < SAME_ENTRY_GAP; i++) begin
               hv_q[i]   <= hv_q[i-1] & ~flush_bp_i;
               hidx_q[i] <= hidx_q[i-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed checks of queueing, pacing, filtering, flush and reset.
module tb_bht_update_queue;
   logic clk = 1'b0, rst_ni = 1'b0, flush = 1'b0, dbg = 1'b0;
   logic vld = 1'b0, cbr = 1'b0, tkn = 1'b0;
   logic [31:0] pc = '0;
   logic ready;
   config_pkg::bht_update_default_t upd;
   logic [2:0] pend;
   int n_assert = 0, n_fail = 0;
   always #5 clk = ~clk;
   bht_update_queue dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_bp_i(flush), .debug_mode_i(dbg),
      .res_valid_i(vld), .res_ready_o(ready), .res_is_cbranch_i(cbr),
      .res_pc_i(pc), .res_taken_i(tkn), .bht_update_o(upd), .pending_o(pend)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic drv(input logic v, input logic c, input logic [31:0] p, input logic t);
      vld = v;
      cbr = c;
      pc  = p;
      tkn = t;
      #1;
   endtask
   function automatic logic [63:0] u(input logic [31:0] p, input logic t);
      return {30'd0, 1'b1, p, t};
   endfunction
   int iss [7] = '{1, 4, 7, 10, 13, 16, 19};
   int cnt [21] = '{0, 1, 1, 2, 3, 3, 4, 4, 3, 4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0};
   initial begin
      logic [63:0] e;
      #3;
      chk("rst_upd", 64'(upd), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_pend", 64'(pend), 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      cyc;
      // single branch
      drv(1, 1, 32'h80000010, 1);
      chk("single_c0_upd", 64'(upd), 64'd0);
      cyc;
      drv(0, 0, 0, 0);
      chk("single_c1_pend", 64'(pend), 64'd1);
      chk("single_c1_upd", 64'(upd), u(32'h80000010, 1));
      cyc;
      chk("single_c2_pend", 64'(pend), 64'd0);
      chk("single_c2_upd", 64'(upd), 64'd0);
      cyc;
      cyc;
      // same-index hazard then blocked younger entry
      drv(1, 1, 32'h100, 1);
      chk("haz_c0", 64'(upd), 64'd0);
      cyc;
      drv(1, 1, 32'h100, 0);
      chk("haz_c1", 64'(upd), u(32'h100, 1));
      cyc;
      drv(1, 1, 32'h104, 1);
      chk("haz_c2", 64'(upd), 64'd0);
      cyc;
      drv(0, 0, 0, 0);
      chk("haz_c3", 64'(upd), 64'd0);
      chk("haz_c3_pend", 64'(pend), 64'd2);
      cyc;
      chk("haz_c4", 64'(upd), u(32'h100, 0));
      cyc;
      chk("haz_c5", 64'(upd), u(32'h104, 1));
      cyc;
      chk("haz_c6", 64'(upd), 64'd0);
      chk("haz_c6_pend", 64'(pend), 64'd0);
      cyc;
      cyc;
      // distinct indices stream one per cycle
      drv(1, 1, 32'h200, 0);
      cyc;
      drv(1, 1, 32'h204, 1);
      chk("thr_c1", 64'(upd), u(32'h200, 0));
      cyc;
      drv(1, 1, 32'h208, 0);
      chk("thr_c2", 64'(upd), u(32'h204, 1));
      cyc;
      drv(0, 0, 0, 0);
      chk("thr_c3", 64'(upd), u(32'h208, 0));
      cyc;
      chk("thr_c4", 64'(upd), 64'd0);
      cyc;
      cyc;
      // fill through same-index pacing: entries k*0x1000 all map to index 0
      for (int c = 0; c <= 20; c++) begin
         if (c < 6) drv(1, 1, 32'(c + 1) * 32'h1000, 1'((c + 1) & 1));
         else if (c <= 8) drv(1, 1, 32'h7000, 1);
         else drv(0, 0, 0, 0);
         e = 64'd0;
         for (int k = 0; k < 7; k++) if (iss[k] == c) e = u(32'(k + 1) * 32'h1000, 1'((k + 1) & 1));
         chk($sformatf("fill_c%0d_upd", c), 64'(upd), e);
         chk($sformatf("fill_c%0d_pend", c), 64'(pend), 64'(cnt[c]));
         chk($sformatf("fill_c%0d_ready", c), 64'(ready), 64'(cnt[c] != 4));
         if (c < 20) cyc;
      end
      cyc;
      cyc;
      // non-branch and debug-mode branch are both consumed and dropped
      drv(1, 0, 32'h400, 1);
      chk("filt_c0_ready", 64'(ready), 64'd1);
      cyc;
      dbg = 1'b1;
      drv(1, 1, 32'h404, 1);
      chk("filt_c1_ready", 64'(ready), 64'd1);
      chk("filt_c1_pend", 64'(pend), 64'd0);
      cyc;
      dbg = 1'b0;
      drv(0, 0, 0, 0);
      chk("filt_c2_pend", 64'(pend), 64'd0);
      chk("filt_c2_upd", 64'(upd), 64'd0);
      cyc;
      // debug holds an already queued entry
      drv(1, 1, 32'h500, 1);
      cyc;
      dbg = 1'b1;
      drv(1, 1, 32'h504, 0);
      chk("dbg_c4_upd", 64'(upd), 64'd0);
      cyc;
      drv(0, 0, 0, 0);
      chk("dbg_c5_pend", 64'(pend), 64'd1);
      chk("dbg_c5_upd", 64'(upd), 64'd0);
      cyc;
      dbg = 1'b0;
      drv(0, 0, 0, 0);
      chk("dbg_c6_upd", 64'(upd), u(32'h500, 1));
      cyc;
      chk("dbg_c7_pend", 64'(pend), 64'd0);
      cyc;
      cyc;
      // flush with a simultaneous push while 3 entries wait
      for (int c = 0; c < 4; c++) begin
         drv(1, 1, 32'(c + 1) * 32'h1000, 1);
         cyc;
      end
      flush = 1'b1;
      drv(1, 1, 32'h5000, 1);
      chk("flush_c4_pend", 64'(pend), 64'd3);
      chk("flush_c4_upd", 64'(upd), 64'd0);
      cyc;
      flush = 1'b0;
      drv(0, 0, 0, 0);
      chk("flush_c5_pend", 64'(pend), 64'd0);
      chk("flush_c5_upd", 64'(upd), 64'd0);
      chk("flush_c5_ready", 64'(ready), 64'd1);
      cyc;
      chk("flush_c6_upd", 64'(upd), 64'd0);
      cyc;
      cyc;
      // asynchronous reset while two entries wait and one issues
      drv(1, 1, 32'h1000, 1);
      cyc;
      drv(1, 1, 32'h2000, 0);
      cyc;
      drv(1, 1, 32'h700, 1);
      cyc;
      drv(0, 0, 0, 0);
      cyc;
      drv(0, 0, 0, 0);
      chk("arst_c4_pend", 64'(pend), 64'd2);
      chk("arst_c4_upd", 64'(upd), u(32'h2000, 0));
      rst_ni = 1'b0;
      #1;
      chk("arst_low_upd", 64'(upd), 64'd0);
      chk("arst_low_pend", 64'(pend), 64'd0);
      chk("arst_low_ready", 64'(ready), 64'd1);
      #4;
      rst_ni = 1'b1;
      cyc;
      chk("arst_after1_upd", 64'(upd), 64'd0);
      chk("arst_after1_pend", 64'(pend), 64'd0);
      cyc;
      chk("arst_after2_upd", 64'(upd), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
